lenet_mac_accumulator: RTL and testbench
========================================

// Module: lenet_mac_accumulator
// PURPOSE
//  Downstream consumer of the 8x8 unsigned approximate multipliers used in the LeNet datapath.
//  Accepts a stream of 16-bit products and sums exactly LEN of them into one window (one conv output pixel).
//  Presents each completed dot-product sum through a single-entry valid/ready output buffer to the activation/requant stage.
// PARAMETERS
//  PROD_W  16  width of incoming product (multiplier z output)
//  ACC_W   24  accumulator / result width; must be >= PROD_W
//  LEN     25  products per window (5x5 kernel); legal range 1..2^16-1
//  CNT_W   16  window counter width; must hold LEN-1
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst_n      in   1       synchronous reset, active-low
//  in_valid   in   1       in_prod is valid this cycle
//  in_ready   out  1       block can accept a product this cycle
//  in_prod    in   PROD_W  unsigned product from multiplier stage
//  out_valid  out  1       out_sum/out_ovf hold a completed window
//  out_ready  in   1       downstream accepts out_sum this cycle
//  out_sum    out  ACC_W   unsigned sum of LEN products
//  out_ovf    out  1       window overflowed ACC_W during accumulation
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0.
//  - Reset mid-window discards the partial sum; the next accepted beat is beat 0 of a new window.
//  - States: ACCUM (in_ready=1), HOLD (in_ready=0, out_valid=1). in_ready is a pure decode of state.
//  - Accept = in_valid & in_ready. in_prod is zero-extended to ACC_W+1 bits; sum = acc + prod.
//  - Accept with cnt<LEN-1: acc<=sum[ACC_W-1:0], ovf<=ovf|sum[ACC_W], cnt<=cnt+1.
//  - Accept with cnt==LEN-1: out_sum<=sum[ACC_W-1:0], out_ovf<=ovf|sum[ACC_W], out_valid<=1,
//    acc<=0, cnt<=0, ovf<=0, state->HOLD. Result is visible the cycle after the last accept (latency 1).
//  - LEN==1: every accept completes a window immediately.
//  - HOLD: out_sum/out_ovf stable while out_valid=1 & out_ready=0. in_valid is ignored (not accepted).
//  - out_valid & out_ready: out_valid<=0, state->ACCUM; in_ready rises the following cycle
//    (no same-cycle accept of the next window's first beat).
//  - out_ready while out_valid=0 has no effect. in_prod ignored when not accepted.
//  - Wrap mode (default): accumulator wraps modulo 2^ACC_W; out_ovf flags any carry-out in the window.
// CONFIGURATION
//  ACC_SATURATE_EN defined: on carry-out, acc (or out_sum on the final beat) clamps to {ACC_W{1'b1}}
//    and stays there for the rest of the window; out_ovf still set.
//  ACC_SATURATE_EN undefined: wrap behaviour as above; no clamp logic instantiated.
// TESTING
//  1. LEN=25, 25 beats in_prod=1, out_ready=1 -> one out_valid pulse, out_sum=25, out_ovf=0.
//  2. LEN=25, 25 beats in_prod=16'hFE01 (255*255) -> out_sum=1625625 (24'h18CE19), out_ovf=0.
//  3. Hold out_ready=0 10 cycles after completion with in_valid=1 -> in_ready=0, out_sum stable,
//     no beats consumed; release -> handshake, in_ready=1 next cycle, next window starts from 0.
//  4. ACC_W=16, LEN=2, beats 16'hFFFF,16'h0002 -> wrap: out_sum=16'h0001, out_ovf=1;
//     with ACC_SATURATE_EN: out_sum=16'hFFFF, out_ovf=1.
//  5. LEN=25, 10 beats of 7, rst_n=0 one cycle, then 25 beats of 3 -> out_sum=75, out_valid=0 during reset.
//  6. Random in_valid/out_ready toggling, 1000 windows, random products -> every out_sum equals
//     scoreboard sum mod 2^ACC_W; no dropped or duplicated beats.

Source files
------------

// File: rtl/lenet_mac_accumulator_if.sv
// Product-in / window-sum-out stream bundle for lenet_mac_accumulator.
// slave = accumulator side, master = producer/consumer environment side.
interface lenet_mac_accumulator_if #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/lenet_mac_accumulator.sv
// Sums LEN unsigned products per window and holds each result in a one-entry valid/ready buffer.
// Define ACC_SATURATE_EN to clamp on carry-out instead of wrapping modulo 2^ACC_W.
module lenet_mac_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LEN    = 25,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lenet_mac_accumulator_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] next_val;
    logic             accept;
    logic             last_beat;

    assign bus.in_ready  = (state == ACCUM);
    // out_valid is set exactly on entry to HOLD and cleared on leaving it, so it decodes from state
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        sum       = {1'b0, acc} + (ACC_W + 1)'(bus.in_prod);
        carry     = ovf | sum[ACC_W];
        accept    = bus.in_valid & bus.in_ready;
        last_beat = (cnt == LAST_CNT);
`ifdef ACC_SATURATE_EN
        // once clamped, acc is all-ones so every later nonzero beat carries again and re-clamps
        next_val  = carry ? '1 : sum[ACC_W-1:0];
`else
        next_val  = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_beat) state_nxt = HOLD;
            HOLD:    if (bus.out_ready)       state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                sum_q <= next_val;
                ovf_q <= carry;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else begin
                acc   <= next_val;
                ovf   <= carry;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lenet_mac_accumulator.sv
// Directed and randomized checks for lenet_mac_accumulator (LEN=25/ACC_W=24 and LEN=2/ACC_W=16 instances).
// Expected values follow ACC_SATURATE_EN when the bench is built with it.
module tb_lenet_mac_accumulator;
    localparam int unsigned LEN2  = 2;
    localparam int unsigned ACC2  = 16;
    localparam int unsigned NWIN  = 1000;

    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;

    lenet_mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) if1 ();
    lenet_mac_accumulator_if #(.PROD_W(16), .ACC_W(ACC2)) if2 ();

    lenet_mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(25), .CNT_W(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    lenet_mac_accumulator #(.PROD_W(16), .ACC_W(ACC2), .LEN(LEN2), .CNT_W(16)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [15:0] p);
        int unsigned n;
        n = 0;
        @(negedge clk);
        if1.in_valid = 1'b1;
        if1.in_prod  = p;
        while (!if1.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("push1_timeout", n, 0);
    endtask

    task automatic push2(input logic [15:0] p);
        int unsigned n;
        n = 0;
        @(negedge clk);
        if2.in_valid = 1'b1;
        if2.in_prod  = p;
        while (!if2.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("push2_timeout", n, 0);
    endtask

    // window result model for the LEN2/ACC2 instance
    logic [ACC2-1:0] exp_sum_q[$];
    logic            exp_ovf_q[$];

    initial begin
        logic [ACC2-1:0] m_acc;
        logic [ACC2:0]   m_s;
        logic            m_ovf;
        int unsigned     m_cnt;
        int unsigned     windows;
        int unsigned     cyc;
        logic [ACC2-1:0] e_sum;
        logic            e_ovf;
        logic [15:0]     exp4;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.in_prod = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_prod = '0; if2.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_in_ready",  if1.in_ready, 1);
        check_eq("rst_out_valid", if1.out_valid, 0);
        check_eq("rst_out_sum",   if1.out_sum, 0);
        check_eq("rst_out_ovf",   if1.out_ovf, 0);
        rst_n = 1'b1;

        // 25 ones with the consumer always ready
        if1.out_ready = 1'b1;
        repeat (25) push1(16'd1);
        @(negedge clk);
        if1.in_valid = 1'b0;
        check_eq("t1_valid", if1.out_valid, 1);
        check_eq("t1_sum",   if1.out_sum, 25);
        check_eq("t1_ovf",   if1.out_ovf, 0);
        check_eq("t1_inrdy", if1.in_ready, 0);
        @(negedge clk);
        check_eq("t1_pulse", if1.out_valid, 0);
        check_eq("t1_inrdy_back", if1.in_ready, 1);

        // 25 x 255*255, then stall the consumer while the producer keeps offering beats
        if1.out_ready = 1'b0;
        repeat (25) push1(16'hFE01);
        @(negedge clk);
        if1.in_prod = 16'd5;
        check_eq("t2_valid", if1.out_valid, 1);
        check_eq("t2_sum",   if1.out_sum, 32'h18CE19);
        check_eq("t2_ovf",   if1.out_ovf, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t3_hold_inrdy", if1.in_ready, 0);
            check_eq("t3_hold_valid", if1.out_valid, 1);
            check_eq("t3_hold_sum",   if1.out_sum, 32'h18CE19);
        end
        if1.out_ready = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        check_eq("t3_rel_valid", if1.out_valid, 0);
        check_eq("t3_rel_inrdy", if1.in_ready, 1);
        repeat (25) push1(16'd2);
        @(negedge clk);
        if1.in_valid = 1'b0;
        check_eq("t3_next_valid", if1.out_valid, 1);
        check_eq("t3_next_sum",   if1.out_sum, 50);
        @(negedge clk);
        check_eq("t3_next_drain", if1.out_valid, 0);

        // reset mid-window discards the partial sum
        repeat (10) push1(16'd7);
        @(negedge clk);
        if1.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t5_rst_valid", if1.out_valid, 0);
        check_eq("t5_rst_inrdy", if1.in_ready, 1);
        rst_n = 1'b1;
        repeat (25) push1(16'd3);
        @(negedge clk);
        if1.in_valid = 1'b0;
        check_eq("t5_valid", if1.out_valid, 1);
        check_eq("t5_sum",   if1.out_sum, 75);
        check_eq("t5_ovf",   if1.out_ovf, 0);
        @(negedge clk);

        // carry-out on a 16-bit accumulator
`ifdef ACC_SATURATE_EN
        exp4 = 16'hFFFF;
`else
        exp4 = 16'h0001;
`endif
        if2.out_ready = 1'b0;
        push2(16'hFFFF);
        push2(16'h0002);
        @(negedge clk);
        if2.in_valid = 1'b0;
        check_eq("t4_valid", if2.out_valid, 1);
        check_eq("t4_sum",   if2.out_sum, exp4);
        check_eq("t4_ovf",   if2.out_ovf, 1);
        if2.out_ready = 1'b1;
        @(negedge clk);
        check_eq("t4_drain", if2.out_valid, 0);
        push2(16'd1);
        push2(16'd2);
        @(negedge clk);
        if2.in_valid = 1'b0;
        check_eq("t4_clr_sum", if2.out_sum, 3);
        check_eq("t4_clr_ovf", if2.out_ovf, 0);
        @(negedge clk);

        // random handshakes against the window model
        m_acc = '0; m_ovf = 1'b0; m_cnt = 0; windows = 0; cyc = 0;
        while (windows < NWIN && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if2.in_valid  = ($urandom_range(0, 1) == 1);
            if2.in_prod   = 16'($urandom);
            if2.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (if2.in_valid && if2.in_ready) begin
                m_s = {1'b0, m_acc} + {1'b0, if2.in_prod};
                if (m_s[ACC2]) m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
                m_acc = m_ovf ? '1 : m_s[ACC2-1:0];
`else
                m_acc = m_s[ACC2-1:0];
`endif
                m_cnt++;
                if (m_cnt == LEN2) begin
                    exp_sum_q.push_back(m_acc);
                    exp_ovf_q.push_back(m_ovf);
                    m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
                end
            end
            if (if2.out_valid && if2.out_ready) begin
                check_eq("rnd_expected_avail", exp_sum_q.size(), 1);
                if (exp_sum_q.size() > 0) begin
                    e_sum = exp_sum_q.pop_front();
                    e_ovf = exp_ovf_q.pop_front();
                    check_eq("rnd_sum", if2.out_sum, e_sum);
                    check_eq("rnd_ovf", if2.out_ovf, e_ovf);
                end
                windows++;
            end
        end
        check_eq("rnd_windows", windows, NWIN);
        @(negedge clk);
        if2.in_valid = 1'b0;
        if2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rnd_leftover", exp_sum_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
